ofifo_align: RTL and testbench
==============================

Name: ofifo_align

Overview:
- Output FIFO bank that sits directly downstream of the MAC array.
- Collects the per-column psum and fifo_wr pairs. These arrive skewed by one cycle per column because of the instruction pipeline.
- Realigns them into complete rows, one psum per column, and presents a row for read only when every column holds at least one entry.
- Feeds the accumulation/SFP stage and the core's output path.

Parameters:
- col, 8, number of MAC columns / FIFO lanes
- bw_psum, 20, psum width per column (2*bw+4 with bw=8)
- depth, 16, entries per column; must be a power of 2, minimum 2

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- wr  input  col  per-column write strobe (column fifo_wr), bit i = column i
- in  input  col*bw_psum  concatenated psums, column i at [(i+1)*bw_psum-1 : i*bw_psum]
- rd  input  1  pop one aligned row
- out  output  col*bw_psum  head row, same packing as in
- o_valid  output  1  every column non-empty; a row is readable
- o_full  output  1  at least one column is full
- o_ready  output  1  ~o_full; upstream may issue execute
- o_overflow  output  1  sticky: a write to a full column was dropped

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high.
- Reset values:
  - All read/write pointers and counts = 0.
  - o_valid=0, o_full=0, o_ready=1, o_overflow=0.
  - Storage is not cleared. out is don't-care whenever o_valid=0; the bench must mask it.
- Per-column FIFO i, circular buffer:
  - Write pointer and read pointer are log2(depth) bits and wrap modulo depth.
  - count is log2(depth)+1 bits.
- Write:
  - Accepted when wr[i]=1 and (count_i<depth or pop this cycle).
  - Stores in slice i at the write pointer, then advances the write pointer.
  - A write to a full column with no simultaneous pop is dropped, and o_overflow is set. o_overflow stays set until reset.
- Pop:
  - pop = rd & o_valid.
  - All columns advance their read pointer together in the same cycle.
  - rd while o_valid=0 is ignored; no state change and no error.
- Simultaneous write and pop on a column: both take effect and count_i is unchanged. This includes the full and count==1 cases.
- Output timing:
  - Fall-through: out and o_valid are combinational from the head entries and counts.
  - Latency from the last column's write edge to o_valid=1 is 1 cycle; a row is visible the cycle after its final write.
- Skew handling:
  - Column i's write of row k arrives i cycles after column 0's.
  - Rows never mix, because each column is strictly in-order and pops are lockstep.
- Flags:
  - o_valid = AND over columns of (count_i != 0).
  - o_full = OR over columns of (count_i == depth).
- Reset asserted mid-burst: the next cycle shows all columns empty, and writes in the reset cycle are discarded.
- Arithmetic: data is opaque, with no sign extension or modification; psums pass bit-exact.

Optional Feature:
- Macro: OFIFO_ALIGN_LEVEL_EN.
- When defined:
  - Adds output port o_level, width log2(depth)+1.
  - o_level is the number of complete rows available, i.e. min over columns of count_i. It is registered, reset value 0, and lags the counts by 1 cycle.
- When undefined:
  - The port and logic are absent.
  - All other behaviour is identical.

Decomposition:
- Shared package (core-level): OFIFO_DEPTH and its log2 derivative, and the PSUM_BW constant shared with the MAC column.
- One natural sub-module: ofifo_lane. It is a single-column parameterised FIFO with ports wr, pop, din, dout, empty, full and count, instantiated col times via generate.
- Top-level logic: the o_valid/o_full reduction, the overflow flag, and the optional level computation.

Test Plan:
- Skewed fill: column i writes row value 0x100*i+k at cycle k+i for k=0..3.
  - o_valid rises exactly the cycle after column 7's first write.
  - Four rd pops return rows k=0..3 in order with exact values.
- rd with empty FIFO (after reset, rd=1 for 3 cycles):
  - Pointers stay 0 and o_valid stays 0.
  - A later single-row write reads back correctly.
- Fill all columns to 16:
  - o_full=1 and o_ready=0.
  - A 17th write on column 2 is dropped and sets o_overflow=1.
  - The sticky flag survives pops and clears only on reset.
- Full plus simultaneous rd and wr on all columns:
  - Count stays 16 and no overflow.
  - The popped row is row 0; the new row appears as row 16 after 15 more pops.
- Pointer wrap: stream 40 rows with interleaved rd, keeping occupancy between 1 and 15 → all 40 rows return in order and bit-exact.
- Reset asserted with 5 rows queued and writes in flight → next cycle o_valid=0 and o_level=0 (if enabled); a subsequent row reads correctly.

Source files
------------

// File: rtl/ofifo_align_pkg.sv
// Core-level constants shared by the output FIFO bank and the MAC column.
package ofifo_align_pkg;
  localparam int OFIFO_COL   = 8;
  localparam int OFIFO_DEPTH = 16;
  localparam int OFIFO_AW    = $clog2(OFIFO_DEPTH);
  localparam int PSUM_BW     = 20;
endpackage

// File: rtl/ofifo_lane.sv
// Single-column circular FIFO with fall-through head. A write to a full lane
// is accepted only when the same cycle pops, so occupancy never exceeds DEPTH.
module ofifo_lane
  import ofifo_align_pkg::*;
#(
  parameter int DEPTH = OFIFO_DEPTH,
  parameter int BW    = PSUM_BW,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          pop,
  input  logic [BW-1:0] din,
  output logic [BW-1:0] dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_acc;

  assign w_acc = wr & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_acc) r_wptr <= r_wptr + 1'b1;
      if (pop)   r_rptr <= r_rptr + 1'b1;
      if (w_acc & ~pop)      r_count <= r_count + 1'b1;
      else if (~w_acc & pop) r_count <= r_count - 1'b1;
    end
  end

  // Storage is never cleared; pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (w_acc & ~reset) r_mem[r_wptr] <= din;
  end

  assign dout  = r_mem[r_rptr];
  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
endmodule

// File: rtl/ofifo_align.sv
// Output FIFO bank: realigns column-skewed psums into rows, lockstep pop.
// Optional OFIFO_ALIGN_LEVEL_EN adds a registered complete-row count o_level.
module ofifo_align
  import ofifo_align_pkg::*;
#(
  parameter int col     = OFIFO_COL,
  parameter int bw_psum = PSUM_BW,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col-1:0]         wr,
  input  logic [col*bw_psum-1:0] in,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
`ifdef OFIFO_ALIGN_LEVEL_EN
  output logic [$clog2(depth):0] o_level,
`endif
  output logic                   o_overflow
);
  localparam int AW = $clog2(depth);

  logic [col-1:0]       w_empty, w_full;
  logic [col-1:0][AW:0] w_count;
  logic                 w_pop;
  logic                 r_overflow;

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(.DEPTH(depth), .BW(bw_psum)) u_lane (
      .clk   (clk),
      .reset (reset),
      .wr    (wr[g]),
      .pop   (w_pop),
      .din   (in[g*bw_psum +: bw_psum]),
      .dout  (out[g*bw_psum +: bw_psum]),
      .empty (w_empty[g]),
      .full  (w_full[g]),
      .count (w_count[g])
    );
  end

  assign o_valid = ~|w_empty;
  assign o_full  = |w_full;
  assign o_ready = ~o_full;
  assign w_pop   = rd & o_valid;

  always_ff @(posedge clk) begin
    if (reset)                                   r_overflow <= 1'b0;
    else if (|(wr & w_full & ~{col{w_pop}}))     r_overflow <= 1'b1;
  end
  assign o_overflow = r_overflow;

`ifdef OFIFO_ALIGN_LEVEL_EN
  logic [AW:0] w_min, r_level;

  always_comb begin
    w_min = w_count[0];
    for (int i = 1; i < col; i++)
      if (w_count[i] < w_min) w_min = w_count[i];
  end

  always_ff @(posedge clk) begin
    if (reset) r_level <= '0;
    else       r_level <= w_min;
  end
  assign o_level = r_level;
`else
  logic unused_count;
  assign unused_count = ^w_count;
`endif
endmodule

// File: tb/tb_ofifo_align.sv
// Self-checking bench for ofifo_align: skew table, corner sequences, random vs queue model.
module tb_ofifo_align;
  localparam int C = 8, BW = 20, D = 16;
  localparam int W = C*BW;

  logic         clk = 1'b0;
  logic         reset, rd;
  logic [C-1:0] wr;
  logic [W-1:0] in, out;
  logic         o_valid, o_full, o_ready, o_overflow;
`ifdef OFIFO_ALIGN_LEVEL_EN
  logic [4:0]   o_level;
`endif

  always #5 clk = ~clk;

  ofifo_align #(.col(C), .bw_psum(BW), .depth(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr),
    .in         (in),
    .rd         (rd),
    .out        (out),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
`ifdef OFIFO_ALIGN_LEVEL_EN
    .o_level    (o_level),
`endif
    .o_overflow (o_overflow)
  );

  int n_cmp = 0, n_bad = 0;

  // Reference model: one queue per column plus sticky flag and lagged level.
  logic [BW-1:0] mq [C][$];
  bit            m_ovf;
  int            m_lvl;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chkr(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic bit mvalid();
    for (int i = 0; i < C; i++) if (mq[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit mfull();
    for (int i = 0; i < C; i++) if (mq[i].size() == D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W-1:0] mhead();
    logic [W-1:0] h = '0;
    for (int i = 0; i < C; i++) h[i*BW +: BW] = mq[i][0];
    return h;
  endfunction

  function automatic logic [W-1:0] rowv(input int k);
    logic [W-1:0] r = '0;
    for (int i = 0; i < C; i++) r[i*BW +: BW] = 20'(256*i + k);
    return r;
  endfunction

  function automatic logic [W-1:0] rndrow();
    logic [W-1:0] r = '0;
    for (int i = 0; i < C; i++) r[i*BW +: BW] = 20'($urandom);
    return r;
  endfunction

  // One clock: drive inputs, advance the model, check all outputs after the edge.
  task automatic cyc(input logic rst, input logic [C-1:0] w, input logic [W-1:0] d, input logic r);
    bit pop;
    int mn;
    reset = rst; wr = w; in = d; rd = r;
    pop = r && mvalid();
    mn = D;
    for (int i = 0; i < C; i++) if (mq[i].size() < mn) mn = mq[i].size();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < C; i++) mq[i].delete();
      m_ovf = 1'b0;
      m_lvl = 0;
    end else begin
      m_lvl = mn;
      for (int i = 0; i < C; i++) begin
        if (pop) void'(mq[i].pop_front());
        if (w[i]) begin
          if (mq[i].size() < D) mq[i].push_back(d[i*BW +: BW]);
          else m_ovf = 1'b1;
        end
      end
    end
    #1;
    chk1("valid", o_valid, mvalid());
    chk1("full", o_full, mfull());
    chk1("ready", o_ready, !mfull());
    chk1("overflow", o_overflow, m_ovf);
    if (mvalid()) chkr("row", out, mhead());
`ifdef OFIFO_ALIGN_LEVEL_EN
    chki("level", int'(o_level), m_lvl);
`endif
  endtask

  typedef struct {
    logic [C-1:0] w;
    logic         r;
    logic         ev;
    int           er;
  } vec_t;

  initial begin
    vec_t         tv [13];
    logic [W-1:0] d;
    logic [W-1:0] eq [$];
    int           n;

    tv[0]  = '{8'h01, 1'b0, 1'b0, 0};
    tv[1]  = '{8'h03, 1'b0, 1'b0, 0};
    tv[2]  = '{8'h07, 1'b0, 1'b0, 0};
    tv[3]  = '{8'h0F, 1'b0, 1'b0, 0};
    tv[4]  = '{8'h1E, 1'b0, 1'b0, 0};
    tv[5]  = '{8'h3C, 1'b0, 1'b0, 0};
    tv[6]  = '{8'h78, 1'b0, 1'b0, 0};
    tv[7]  = '{8'hF0, 1'b0, 1'b1, 0};
    tv[8]  = '{8'hE0, 1'b1, 1'b1, 1};
    tv[9]  = '{8'hC0, 1'b1, 1'b1, 2};
    tv[10] = '{8'h80, 1'b1, 1'b1, 3};
    tv[11] = '{8'h00, 1'b1, 1'b0, 0};
    tv[12] = '{8'h00, 1'b1, 1'b0, 0};

    reset = 1'b1; wr = '0; in = '0; rd = 1'b0;
    cyc(1, '0, '0, 0);
    cyc(1, '0, '0, 0);
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_full", o_full, 1'b0);
    chk1("rst_ready", o_ready, 1'b1);
    chk1("rst_ovf", o_overflow, 1'b0);

    // Skewed fill: column i writes row k at cycle k+i.
    for (int t = 0; t < 13; t++) begin
      d = '0;
      for (int i = 0; i < C; i++) d[i*BW +: BW] = 20'(256*i + t - i);
      cyc(0, tv[t].w, d, tv[t].r);
      chk1("tbl_valid", o_valid, tv[t].ev);
      if (tv[t].ev) chkr("tbl_row", out, rowv(tv[t].er));
    end

    // rd on an empty bank is ignored.
    cyc(1, '0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, '0, '0, 1);
      chk1("empty_rd_valid", o_valid, 1'b0);
    end
    cyc(0, 8'hFF, rowv(8'h55), 0);
    chkr("single_row", out, rowv(8'h55));
    cyc(0, '0, '0, 1);
    chk1("single_drained", o_valid, 1'b0);

    // Fill to depth, drop a write on column 2, flag stays sticky through pops.
    cyc(1, '0, '0, 0);
    for (int k = 0; k < D; k++) cyc(0, 8'hFF, rowv(8'h40 + k), 0);
    chk1("full16", o_full, 1'b1);
    chk1("ready16", o_ready, 1'b0);
    cyc(0, 8'h04, rowv(8'h99), 0);
    chk1("ovf_set", o_overflow, 1'b1);
    cyc(0, '0, '0, 1);
    cyc(0, '0, '0, 1);
    chk1("ovf_sticky", o_overflow, 1'b1);
    chkr("after_pops", out, rowv(8'h42));
    cyc(1, '0, '0, 0);
    chk1("ovf_cleared", o_overflow, 1'b0);

    // Full with simultaneous rd and wr on every column.
    for (int k = 0; k < D; k++) cyc(0, 8'hFF, rowv(12'h200 + k), 0);
    cyc(0, 8'hFF, rowv(12'h2FF), 1);
    chk1("fullrw_full", o_full, 1'b1);
    chk1("fullrw_ovf", o_overflow, 1'b0);
    chkr("fullrw_head", out, rowv(12'h201));
    for (int k = 0; k < 15; k++) cyc(0, '0, '0, 1);
    chkr("fullrw_row16", out, rowv(12'h2FF));
    chk1("fullrw_last", o_valid, 1'b1);

    // Pointer wrap: stream 40 rows with interleaved reads, occupancy kept small.
    cyc(1, '0, '0, 0);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      logic r;
      r = (c >= 4);
      if (r && o_valid) begin
        if (eq.size() != 0) chkr("stream", out, eq.pop_front());
        else chk1("stream_extra", o_valid, 1'b0);
      end
      if (n < 40) begin
        d = rndrow();
        eq.push_back(d);
        n++;
        cyc(0, 8'hFF, d, r);
      end else begin
        cyc(0, '0, '0, r);
      end
      if (n >= 40 && eq.size() == 0 && !o_valid) break;
    end
    chki("stream_left", eq.size(), 0);

    // Reset with rows queued and writes in flight.
    cyc(1, '0, '0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 8'hFF, rowv(12'h300 + k), 0);
    cyc(1, 8'hFF, rowv(12'h3AA), 1);
    chk1("midrst_valid", o_valid, 1'b0);
`ifdef OFIFO_ALIGN_LEVEL_EN
    chki("midrst_level", int'(o_level), 0);
`endif
    cyc(0, 8'hFF, rowv(12'h3BB), 0);
    chk1("postrst_valid", o_valid, 1'b1);
    chkr("postrst_row", out, rowv(12'h3BB));

    // Randomised traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      logic [C-1:0] w;
      logic         r, rs;
      int           ph;
      ph = (c / 100) % 3;
      rs = ($urandom_range(0, 149) == 0);
      w  = ($urandom_range(0, 2) == 0) ? C'($urandom) : 8'hFF;
      if (ph == 0)      r = ($urandom_range(0, 3) == 0);
      else if (ph == 1) r = ($urandom_range(0, 3) != 0);
      else              r = ($urandom_range(0, 1) == 0);
      cyc(rs, w, rndrow(), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
